// File: rtl/lif_if.sv
// lif_if: synaptic inputs and membrane/spike outputs of a LIF neuron
interface lif_if #(parameter int N_SYN = 4);
  logic [N_SYN-1:0] pre;
  logic [18*N_SYN-1:0] w;
  logic post;
  logic signed [17:0] v;
  logic refractory;
  logic [15:0] spike_cnt;
  modport master(output pre, w, input post, v, refractory, spike_cnt);
  modport slave(input pre, w, output post, v, refractory, spike_cnt);
endinterface

// File: rtl/lif_neuron.sv
// lif_neuron: two-stage leaky integrate-and-fire neuron with refractory period
module lif_neuron #(
  parameter int N_SYN = 4,
  parameter logic signed [17:0] V_TH = 18'sh1_0000,
  parameter logic signed [17:0] V_RESET = 18'sh0_0000,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRACT = 8
) (
  input logic clk,
  input logic rst,
  lif_if.slave bus
);
  localparam int RW = REFRACT > 1 ? $clog2(REFRACT + 1) : 1;
  localparam logic signed [20:0] V_MAX = 21'sd131071;
  localparam logic signed [20:0] V_MIN = -21'sd131072;
  typedef enum logic {INTEG, REFR} state_t;
  state_t state, state_d;
  logic signed [20:0] syn_sum, sum_d, acc;
  logic signed [17:0] v, v_d, v_sat, w_i;
  logic post, post_d;
  logic [15:0] spike_cnt, cnt_d;
  logic [RW-1:0] refr_cnt, refr_d;
  always_comb begin
    sum_d = '0;
    w_i = '0;
    for (int i = 0; i < N_SYN; i++) begin
      w_i = bus.w[18*i +: 18];
      sum_d = bus.pre[i] ? sum_d + 21'(w_i) : sum_d;
    end
  end
  // 21-bit headroom holds leak plus the full synaptic sum, so clamp instead of wrapping
  assign acc = 21'(v) - 21'(v >>> LEAK_SHIFT) + syn_sum;
  assign v_sat = acc > V_MAX ? 18'sh1_FFFF : acc < V_MIN ? 18'sh2_0000 : acc[17:0];
  always_comb begin
    state_d = state;
    v_d = v_sat;
    post_d = 1'b0;
    cnt_d = spike_cnt;
    refr_d = refr_cnt;
    if (state == REFR) begin
      v_d = V_RESET;
      refr_d = refr_cnt - RW'(1);
      state_d = refr_cnt == RW'(1) ? INTEG : REFR;
    end else if (v_sat >= V_TH) begin
      v_d = V_RESET;
      post_d = 1'b1;
      cnt_d = spike_cnt + {15'd0, ~&spike_cnt};
      refr_d = RW'(REFRACT);
      state_d = REFRACT == 0 ? INTEG : REFR;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= INTEG;
      syn_sum <= '0;
      v <= V_RESET;
      post <= 1'b0;
      spike_cnt <= '0;
      refr_cnt <= '0;
    end else begin
      state <= state_d;
      syn_sum <= sum_d;
      v <= v_d;
      post <= post_d;
      spike_cnt <= cnt_d;
      refr_cnt <= refr_d;
    end
  assign bus.v = v;
  assign bus.post = post;
  assign bus.refractory = state == REFR;
  assign bus.spike_cnt = spike_cnt;
endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: table-driven scoreboard bench for lif_neuron (REFRACT=8 and REFRACT=0)
module tb_lif_neuron;
  localparam logic [17:0] W9 = 18'h0_9000;
  localparam logic [17:0] WN = 18'h2_0000;
  typedef struct {
    logic rst;
    logic [3:0] pre;
    logic [17:0] w0, w1, w23;
    logic [17:0] v;
    logic post, refr;
    logic [15:0] cnt;
  } vec_t;
  typedef struct {
    int idx;
    logic [17:0] v;
    logic post, refr;
    logic [15:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst, rst0;
  vec_t tbl[$];
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  lif_if #(.N_SYN(4)) bus();
  lif_if #(.N_SYN(4)) bus0();
  lif_neuron #(.N_SYN(4)) dut(.clk(clk), .rst(rst), .bus(bus));
  lif_neuron #(.N_SYN(4), .REFRACT(0)) dut0(.clk(clk), .rst(rst0), .bus(bus0));
  task automatic add(input logic r, input logic [3:0] p, input logic [17:0] a, b, c, ev,
                     input logic ep, er, input logic [15:0] ec, input int n = 1);
    vec_t t;
    t = '{r, p, a, b, c, ev, ep, er, ec};
    for (int k = 0; k < n; k++) tbl.push_back(t);
  endtask
  task automatic compare(input string name, input logic [17:0] v, input logic po, rf, input logic [15:0] cn);
    exp_t e;
    e = sb.pop_front();
    vectors++;
    if ({v, po, rf, cn} !== {e.v, e.post, e.refr, e.cnt}) begin
      miscompares++;
      $display("FAIL %s vec %0d: got v=%h post=%b refr=%b cnt=%0d, want v=%h post=%b refr=%b cnt=%0d",
               name, e.idx, v, po, rf, cn, e.v, e.post, e.refr, e.cnt);
    end
  endtask
  task automatic step(input vec_t r, input int idx);
    @(negedge clk);
    rst = r.rst;
    bus.pre = r.pre;
    bus.w = {r.w23, r.w23, r.w1, r.w0};
    sb.push_back('{idx, r.v, r.post, r.refr, r.cnt});
    @(posedge clk);
    #1;
    compare("main", bus.v, bus.post, bus.refractory, bus.spike_cnt);
  endtask
  task automatic step0(input int idx, input logic po, input logic [15:0] cn);
    @(negedge clk);
    rst0 = 1'b0;
    bus0.pre = 4'b0011;
    bus0.w = {18'h0, 18'h0, W9, W9};
    sb.push_back('{idx, 18'h0, po, 1'b0, cn});
    @(posedge clk);
    #1;
    compare("refract0", bus0.v, bus0.post, bus0.refractory, bus0.spike_cnt);
  endtask
  initial begin
    rst = 1'b1;
    rst0 = 1'b1;
    bus.pre = '0;
    bus.w = '0;
    bus0.pre = '0;
    bus0.w = '0;
    add(1, 4'hF, W9, W9, W9, 0, 0, 0, 0, 2);
    add(0, 4'h1, W9, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 18'h0_9000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 18'h0_8700, 0, 0, 0);
    add(0, 0, 0, 0, 0, 18'h0_7E90, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'h3, W9, W9, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 5);
    add(0, 4'h3, W9, W9, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    add(0, 4'h3, W9, W9, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 1, 2, 7);
    add(0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 4'h3, W9, W9, 0, 0, 0, 0, 2);
    add(0, 4'h3, W9, W9, 0, 0, 1, 1, 3);
    add(0, 4'h3, W9, W9, 0, 0, 0, 1, 3, 7);
    add(0, 4'h3, W9, W9, 0, 0, 0, 0, 3);
    add(0, 4'h3, W9, W9, 0, 0, 1, 1, 4);
    add(0, 0, 0, 0, 0, 0, 0, 1, 4);
    add(0, 4'h3, W9, W9, 0, 0, 0, 1, 4);
    add(1, 4'h3, W9, W9, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'h3, W9, W9, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'hF, WN, WN, WN, 0, 0, 0, 0);
    add(0, 4'hF, WN, WN, WN, 18'h2_0000, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 18'h2_0000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 18'h2_2000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 18'h2_3E00, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'h1, 18'h0_FFFF, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 18'h0_FFFF, 0, 0, 0);
    add(0, 4'h1, 18'h0_1F00, 0, 0, 18'h0_F000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'hD, W9, 0, 18'h3_F000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 18'h0_7000, 0, 0, 0);
    foreach (tbl[i]) step(tbl[i], i);
    rst = 1'b1;
    step0(0, 1'b0, 16'd0);
    step0(1, 1'b1, 16'd1);
    step0(2, 1'b1, 16'd2);
    step0(3, 1'b1, 16'd3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lif_neuron.md
LIF_NEURON -- requirements
Module: lif_neuron

Interface
REQ-001 Parameter N_SYN, default 4, number of synaptic inputs.
REQ-002 Parameter V_TH, default 18'sh1_0000, firing threshold (Q2.16 signed, 1.0).
REQ-003 Parameter V_RESET, default 18'sh0_0000, membrane value after a spike.
REQ-004 Parameter LEAK_SHIFT, default 4, leak arithmetic-shift amount.
REQ-005 Parameter REFRACT, default 8, refractory length in cycles (0 allowed).
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 pre  input  N_SYN  presynaptic spike per synapse, sampled every edge.
REQ-009 w  input  18*N_SYN  signed Q2.16 weights; synapse i in bits [18i+17:18i], driven by the per-synapse weight-update blocks.
REQ-010 post  output  1  registered one-cycle postsynaptic spike pulse, fed back to the weight-update blocks.
REQ-011 v  output  18  signed membrane potential register.
REQ-012 refractory  output  1  high while state is REFR.
REQ-013 spike_cnt  output  16  saturating count of emitted spikes.

Function
REQ-014 Stage 1 SHALL register syn_sum (21-bit signed) = sum of sign-extended w_i for every i with pre_i = 1 at that edge; 0 when no pre.
REQ-015 Stage 2 SHALL compute v_next = v - (v >>> LEAK_SHIFT) + syn_sum in 21-bit signed arithmetic, then saturate to [-131072, 131071]; no wrap-around permitted.
REQ-016 Latency: pre sampled at edge k SHALL affect v at edge k+1; a resulting spike SHALL show post = 1 for the cycle after edge k+1 only.
REQ-017 FSM states: INTEG, REFR; reset state INTEG.
REQ-018 INTEG, v_next >= V_TH (signed): v <= V_RESET, post <= 1, spike_cnt += 1 (hold at 0xFFFF), go REFR with refr_cnt <= REFRACT; if REFRACT = 0 stay INTEG.
REQ-019 INTEG, v_next < V_TH: v <= v_next, post <= 0.
REQ-020 REFR: v held at V_RESET, syn_sum at stage 2 discarded (no leak, no integration), post <= 0, refr_cnt decrements; on the edge where refr_cnt = 1, go INTEG with refr_cnt = 0.
REQ-021 refractory SHALL be high for exactly REFRACT consecutive cycles, starting in the same cycle post is high.
REQ-022 Stage 1 SHALL keep sampling during REFR; only pre sampled at or after the edge that returns to INTEG contribute to v.
REQ-023 Weights SHALL be sampled in stage 1 together with pre; weight changes after that edge do not alter the in-flight sum.
REQ-024 post SHALL never be high on two consecutive cycles when REFRACT >= 1.

Reset
REQ-025 rst = 1 at an edge SHALL force v = V_RESET, syn_sum = 0, post = 0, refractory = 0, refr_cnt = 0, spike_cnt = 0, state INTEG, overriding all other activity.
REQ-026 rst asserted mid-refractory or with a sum in flight SHALL discard it; first pre after rst release affects v one edge later as in REQ-016.

Verification
REQ-027 Reset: hold rst 2 cycles with pre all 1 -> v = 0, post = 0, refractory = 0, spike_cnt = 0.
REQ-028 Leak: pre = 4'b0001, w0 = 18'sh0_9000 for one edge -> v = 0x0_9000, next edge (no pre) v = 0x0_8700, post stays 0.
REQ-029 Fire: pre = 4'b0011, w0 = w1 = 18'sh0_9000 from v = 0 -> sum 0x1_2000 >= V_TH, post high one cycle, v = 0, spike_cnt = 1, refractory high 8 cycles.
REQ-030 Refractory boundary: repeat the fire pulse every cycle -> second post occurs exactly 9 cycles after the first; pre on the last refractory cycle contributes nothing.
REQ-031 Saturation: all pre = 1, all w = 18'sh2_0000 for 5 edges -> v pinned at -131072 (18'sh2_0000), no wrap, post = 0.
REQ-032 Reset mid-operation: rst during cycle 3 of refractory -> next cycle refractory = 0, v = 0, spike_cnt = 0; a subsequent fire pulse spikes normally.
